// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter shared by the fetch stage, the MEM stage
// and the interrupt-vector read. After reset it reads the reset vector and
// publishes the initial PC. In run mode it issues one access per cycle:
// vector first, then data, then fetch. Fetch is lifted above data once it has
// been denied FETCH_MAX_WAIT cycles in a row.
module mem_port_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int RESET_VEC_ADDR = 0,
  parameter int INTR_VEC_ADDR  = 1,
  parameter int FETCH_MAX_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_grant,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_grant,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              vec_req,
  output logic              vec_grant,
  output logic              vec_rvalid,
  output logic [DATA_W-1:0] vec_rdata,
  output logic              stall_if,
  output logic              boot_done,
  output logic              pc_init_valid,
  output logic [DATA_W-1:0] pc_init,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WCW = (FETCH_MAX_WAIT < 1) ? 1 : $clog2(FETCH_MAX_WAIT + 1);
  localparam logic [WCW-1:0]    WAIT_MAX  = WCW'(FETCH_MAX_WAIT);
  localparam logic [ADDR_W-1:0] RST_ADDR  = ADDR_W'(RESET_VEC_ADDR);
  localparam logic [ADDR_W-1:0] INTR_ADDR = ADDR_W'(INTR_VEC_ADDR);

  typedef enum logic [1:0] {
    BOOT_RD   = 2'd0,
    BOOT_WAIT = 2'd1,
    RUN       = 2'd2
  } state_t;

  // Identity of the read whose data arrives on mem_rdata next cycle
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_IF   = 2'd1;
  localparam logic [1:0] TAG_DM   = 2'd2;
  localparam logic [1:0] TAG_VEC  = 2'd3;

  state_t            r_state;
  logic [1:0]        r_tag;
  logic [WCW-1:0]    r_wait_cnt;
  logic [DATA_W-1:0] r_pc_init;
  logic              r_pc_init_valid;
  logic              r_boot_done;

  logic w_if_win;
  logic w_dm_win;
  logic w_vec_win;

  // Pick this cycle's winner; fetch may jump ahead of data but never ahead of vector
  always_comb begin
    w_if_win  = 1'b0;
    w_dm_win  = 1'b0;
    w_vec_win = 1'b0;
    if (!rst && (r_state == RUN)) begin
      if (vec_req) begin
        w_vec_win = 1'b1;
      end else if (if_req && (r_wait_cnt == WAIT_MAX)) begin
        w_if_win = 1'b1;
      end else if (dm_req) begin
        w_dm_win = 1'b1;
      end else if (if_req) begin
        w_if_win = 1'b1;
      end else begin
        w_if_win = 1'b0;
      end
    end else begin
      w_if_win = 1'b0;
    end
  end

  // Drive the memory port from the boot state or the current winner; all quiet in reset
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst) begin
      mem_en = 1'b0;
    end else begin
      case (r_state)
        BOOT_RD: begin
          mem_en   = 1'b1;
          mem_addr = RST_ADDR;
        end
        RUN: begin
          if (w_vec_win) begin
            mem_en   = 1'b1;
            mem_addr = INTR_ADDR;
          end else if (w_dm_win) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_we ? dm_wdata : '0;
          end else if (w_if_win) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
          end else begin
            mem_en = 1'b0;
          end
        end
        default: begin
          mem_en = 1'b0;
        end
      endcase
    end
  end

  // Grants, stall and read-return steering; rdata is zero unless its rvalid is set
  always_comb begin
    if_grant   = w_if_win;
    dm_grant   = w_dm_win;
    vec_grant  = w_vec_win;
    stall_if   = if_req & ~w_if_win & ~rst;
    if_rvalid  = (r_tag == TAG_IF);
    dm_rvalid  = (r_tag == TAG_DM);
    vec_rvalid = (r_tag == TAG_VEC);
    if_rdata   = if_rvalid  ? mem_rdata : '0;
    dm_rdata   = dm_rvalid  ? mem_rdata : '0;
    vec_rdata  = vec_rvalid ? mem_rdata : '0;
  end

  // Boot/run state machine with read tag, fetch wait counter and boot outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= BOOT_RD;
      r_tag           <= TAG_NONE;
      r_wait_cnt      <= '0;
      r_pc_init       <= '0;
      r_pc_init_valid <= 1'b0;
      r_boot_done     <= 1'b0;
    end else begin
      case (r_state)
        BOOT_RD: begin
          r_state <= BOOT_WAIT;
          r_tag   <= TAG_NONE;
        end
        BOOT_WAIT: begin
          r_pc_init       <= mem_rdata;
          r_pc_init_valid <= 1'b1;
          r_boot_done     <= 1'b1;
          r_tag           <= TAG_NONE;
          r_state         <= RUN;
        end
        RUN: begin
          r_pc_init_valid <= 1'b0;
          if (w_vec_win) begin
            r_tag <= TAG_VEC;
          end else if (w_dm_win) begin
            r_tag <= dm_we ? TAG_NONE : TAG_DM;
          end else if (w_if_win) begin
            r_tag <= TAG_IF;
          end else begin
            r_tag <= TAG_NONE;
          end
          if (if_req && !w_if_win) begin
            if (r_wait_cnt != WAIT_MAX) begin
              r_wait_cnt <= r_wait_cnt + WCW'(1);
            end else begin
              r_wait_cnt <= r_wait_cnt;
            end
          end else begin
            r_wait_cnt <= '0;
          end
        end
        default: begin
          r_state <= BOOT_RD;
          r_tag   <= TAG_NONE;
        end
      endcase
    end
  end

  assign boot_done     = r_boot_done;
  assign pc_init_valid = r_pc_init_valid;
  assign pc_init       = r_pc_init;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single-port unified memory shared by the fetch stage, the MEM stage (LDD/STD/PUSH/POP/CALL/RET) and the interrupt-vector read issued by the control unit's S_INTR sequence.
- After reset it runs a boot sequence that reads the reset vector and hands the initial PC to the fetch stage.
- In run mode it grants one access per cycle by fixed priority, with anti-starvation for fetch.
- It generates the fetch stall consumed by the PC / IF_ID write enables.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- RESET_VEC_ADDR, 0, address holding the reset PC.
- INTR_VEC_ADDR, 1, address holding the interrupt service PC.
- FETCH_MAX_WAIT, 2, consecutive denied fetch cycles before fetch outranks data access.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch wants an instruction byte.
- if_addr  in  ADDR_W  fetch address.
- if_grant  out  1  fetch read issued this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch read data.
- dm_req  in  1  MEM-stage access request.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_grant  out  1  data access issued this cycle.
- dm_rvalid  out  1  data read valid.
- dm_rdata  out  DATA_W  data read data.
- vec_req  in  1  interrupt vector read request.
- vec_grant  out  1  vector read issued.
- vec_rvalid  out  1  vector data valid.
- vec_rdata  out  DATA_W  vector data.
- stall_if  out  1  fetch requested but not granted.
- boot_done  out  1  boot complete, run mode.
- pc_init_valid  out  1  one-cycle pulse, pc_init valid.
- pc_init  out  DATA_W  reset-vector contents.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; synchronous read, valid the cycle after a read issue.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: while rst=1, every output is 0, the FSM is in BOOT_RD, the outstanding-read tag is NONE and the wait counter is 0.
- FSM states: BOOT_RD -> BOOT_WAIT -> RUN. RUN is held until reset.
- BOOT_RD:
  - mem_en=1, mem_we=0, mem_addr=RESET_VEC_ADDR.
  - All grants are 0. stall_if = if_req.
- BOOT_WAIT:
  - pc_init is registered from mem_rdata. pc_init_valid pulses in the cycle after BOOT_WAIT, together with the rise of boot_done.
  - boot_done stays at 1 until reset.
  - No memory access is issued. All grants are 0.
- RUN arbitration (combinational, same cycle):
  - Priority order: vec_req > dm_req > if_req.
  - Exception: when wait_cnt == FETCH_MAX_WAIT and if_req=1, fetch outranks dm. Fetch never outranks vec.
  - At most one grant per cycle. The winner drives mem_en=1, mem_addr and, for dm writes, mem_we=1 and mem_wdata.
  - With no requester: mem_en=0, mem_we=0.
- Read return:
  - Each granted read registers a tag (IF, DM or VEC).
  - In the next cycle the tagged requester's rvalid=1 and its rdata = mem_rdata (pass-through).
  - A dm write registers tag NONE, so no rvalid follows.
  - Read issue and the previous read's return overlap freely, giving full throughput of 1 access per cycle.
- rdata outputs: when the corresponding rvalid=0, the rdata outputs are 0.
- stall_if: stall_if = if_req & ~if_grant, in every state.
- wait_cnt:
  - Increments when if_req & ~if_grant in RUN, saturating at FETCH_MAX_WAIT.
  - Clears on if_grant or when if_req=0.
- Requester obligations:
  - Requests are held until granted.
  - vec_req is deasserted by the requester after vec_grant.
  - The arbiter does not latch requests.
- Reset mid-operation: any outstanding read is discarded (no rvalid), the boot sequence reruns, and pc_init_valid pulses again.
- Simultaneous vec_req and dm_req with wait_cnt saturated: vec wins, and wait_cnt keeps its saturated value.

Test Plan:
1. mem[0]=0x40, release rst -> cycle 0: mem_en=1, mem_addr=0x00, no grants. Cycle 1: no access. Cycle 2: pc_init_valid=1, pc_init=0x40, boot_done=1. pc_init_valid=0 in cycle 3.
2. Fetch only, if_addr=0x41, mem[0x41]=0xA5 -> if_grant=1 in the same cycle, stall_if=0. Next cycle: if_rvalid=1, if_rdata=0xA5.
3. dm write (addr 0xF0, data 0x3C) together with if_req -> dm_grant=1, mem_we=1, stall_if=1. Next cycle: if_grant=1 and no dm_rvalid. mem[0xF0]=0x3C.
4. dm_req held for 5 cycles with if_req held -> grant pattern dm, dm, if, dm, dm; stall_if=1 exactly on the dm cycles.
5. vec_req, dm_req and if_req all asserted, mem[1]=0x80 -> vec_grant=1 with mem_addr=0x01. Next cycle: vec_rvalid=1, vec_rdata=0x80, and dm is granted.
6. Fetch read granted, then rst asserted before the return cycle -> if_rvalid stays 0 and all outputs are 0. After release, boot reruns and pc_init_valid pulses again.
